// File: rtl/tl_mem_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL SRAM port between Dcache (m0) and Icache (m1).
// One transaction in flight; a D-channel timeout synthesizes a denied response.
module tl_mem_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_a_valid,
    output logic        m0_a_ready,
    input  logic [79:0] m0_a_bits,
    output logic        m0_d_valid,
    input  logic        m0_d_ready,
    output logic [45:0] m0_d_bits,
    input  logic        m1_a_valid,
    output logic        m1_a_ready,
    input  logic [79:0] m1_a_bits,
    output logic        m1_d_valid,
    input  logic        m1_d_ready,
    output logic [45:0] m1_d_bits,
    output logic        s_a_valid,
    input  logic        s_a_ready,
    output logic [79:0] s_a_bits,
    input  logic        s_d_valid,
    output logic        s_d_ready,
    input  logic [45:0] s_d_bits,
    output logic        busy,
    output logic        grant,
    output logic        timeout_pulse
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] A_SEND = 2'd1;
    localparam logic [1:0] D_WAIT = 2'd2;
    localparam logic [1:0] T_RESP = 2'd3;

    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             last;
    logic [CNT_W-1:0] counter;
    logic [79:0]      aBuf;

    logic        winner;
    logic        anyValid;
    logic        gDReady;
    logic        dHs;
    logic        timeoutHit;
    logic [2:0]  tOpcode;
    logic [45:0] tBits;
    logic        respValid;
    logic [45:0] respBits;

    always_comb begin
        anyValid = m0_a_valid || m1_a_valid;
        // On a tie the master that did not win last time gets the port
        winner   = (m0_a_valid && m1_a_valid) ? ~last : m1_a_valid;
        gDReady  = grant ? m1_d_ready : m0_d_ready;
        dHs      = (state == D_WAIT) && s_d_valid && gDReady;
        timeoutHit = (TIMEOUT != 0) && (state == D_WAIT) && !dHs && (counter == T_LAST);

        tOpcode = (aBuf[79:77] == 3'd4) ? 3'd1 : 3'd0;
        tBits   = {tOpcode, aBuf[76:68], 1'b1, 1'b0, 32'd0};

        respValid = 1'b0;
        respBits  = '0;
        s_d_ready = 1'b1;
        case (state)
            D_WAIT: begin
                respValid = s_d_valid;
                respBits  = s_d_bits;
                s_d_ready = gDReady;
            end
            T_RESP: begin
                respValid = 1'b1;
                respBits  = tBits;
                s_d_ready = 1'b0;
            end
            default: ;
        endcase

        m0_a_ready    = (state == IDLE) && anyValid && !winner;
        m1_a_ready    = (state == IDLE) && anyValid && winner;
        m0_d_valid    = respValid && !grant;
        m1_d_valid    = respValid && grant;
        m0_d_bits     = grant ? '0 : respBits;
        m1_d_bits     = grant ? respBits : '0;
        s_a_valid     = (state == A_SEND);
        s_a_bits      = aBuf;
        busy          = (state != IDLE);
        timeout_pulse = timeoutHit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            grant   <= 1'b0;
            counter <= '0;
            aBuf    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        aBuf  <= winner ? m1_a_bits : m0_a_bits;
                        grant <= winner;
                        state <= A_SEND;
                    end
                end
                A_SEND: begin
                    if (s_a_ready) begin
                        state   <= D_WAIT;
                        counter <= '0;
                    end
                end
                D_WAIT: begin
                    if (dHs) begin
                        last  <= grant;
                        state <= IDLE;
                    end else if (timeoutHit) begin
                        state <= T_RESP;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                T_RESP: begin
                    if (gDReady) begin
                        last  <= grant;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// Directed bench for tl_mem_arbiter: arbitration, A-beat hold, D routing, timeout and reset.
module tb_tl_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_a_valid, m0_a_ready, m0_d_valid, m0_d_ready;
    logic [79:0] m0_a_bits;
    logic [45:0] m0_d_bits;
    logic        m1_a_valid, m1_a_ready, m1_d_valid, m1_d_ready;
    logic [79:0] m1_a_bits;
    logic [45:0] m1_d_bits;
    logic        s_a_valid, s_a_ready, s_d_valid, s_d_ready;
    logic [79:0] s_a_bits;
    logic [45:0] s_d_bits;
    logic        busy, grant, timeout_pulse;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    tl_mem_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_bits(m0_a_bits),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_bits(m0_d_bits),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_bits(m1_a_bits),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_bits(m1_d_bits),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_bits(s_a_bits),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_bits(s_d_bits),
        .busy(busy), .grant(grant), .timeout_pulse(timeout_pulse)
    );

    task automatic checkEq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [79:0] mkA(input logic [2:0] op, input logic [4:0] src,
                                        input logic [31:0] addr, input logic [31:0] data);
        return {op, 4'd2, src, 4'hF, addr, data};
    endfunction

    function automatic logic [45:0] mkD(input logic [2:0] op, input logic [4:0] src,
                                        input logic denied, input logic [31:0] data);
        return {op, 4'd2, src, denied, 1'b0, data};
    endfunction

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [79:0] bA0, bA1, bA3, bA4;
    logic [45:0] r0, r1, r5;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        m0_a_valid = 0; m0_a_bits = '0; m0_d_ready = 1;
        m1_a_valid = 0; m1_a_bits = '0; m1_d_ready = 1;
        s_a_ready = 0; s_d_valid = 0; s_d_bits = '0;

        // Reset state
        tick();
        tick();
        #1;
        checkEq("rst_busy", busy, 0);
        checkEq("rst_sdready", s_d_ready, 1);
        checkEq("rst_savalid", s_a_valid, 0);
        checkEq("rst_grant", grant, 0);
        checkEq("rst_sabits", s_a_bits, 0);
        checkEq("rst_tpulse", timeout_pulse, 0);
        checkEq("rst_dvalid", {m0_d_valid, m1_d_valid, m0_a_ready, m1_a_ready}, 0);
        rst = 1'b0;
        tick();

        // Test 1: m0 Get, response one cycle after A accept
        bA0 = mkA(3'd4, 5'd3, 32'h8000_0010, 32'h0);
        m0_a_valid = 1; m0_a_bits = bA0;
        #1;
        checkEq("t1_m0ready", m0_a_ready, 1);
        checkEq("t1_m1ready", m1_a_ready, 0);
        tick();
        m0_a_valid = 0;
        #1;
        checkEq("t1_savalid", s_a_valid, 1);
        checkEq("t1_sabits", s_a_bits, bA0);
        checkEq("t1_busy", busy, 1);
        checkEq("t1_m0ready_as", m0_a_ready, 0);
        s_a_ready = 1;
        tick();
        s_a_ready = 0;
        #1;
        checkEq("t1_dwait_nov", {m0_d_valid, m1_d_valid}, 0);
        tick();
        r0 = mkD(3'd1, 5'd3, 1'b0, 32'hDEAD_BEEF);
        s_d_valid = 1; s_d_bits = r0;
        #1;
        checkEq("t1_m0dvalid", m0_d_valid, 1);
        checkEq("t1_m0dbits", m0_d_bits, r0);
        checkEq("t1_m1dvalid", m1_d_valid, 0);
        checkEq("t1_m1dbits", m1_d_bits, 0);
        checkEq("t1_sdready", s_d_ready, 1);
        tick();
        s_d_valid = 0;
        #1;
        checkEq("t1_idle", busy, 0);
        checkEq("t1_m0dvalid_end", m0_d_valid, 0);

        // Test 2: tie after reset goes to m0, then alternates
        doReset();
        bA0 = mkA(3'd0, 5'd1, 32'h8000_0100, 32'h1234_5678);
        bA1 = mkA(3'd4, 5'd2, 32'h8000_0200, 32'h0);
        m0_a_valid = 1; m0_a_bits = bA0;
        m1_a_valid = 1; m1_a_bits = bA1;
        #1;
        checkEq("t2_tie1_m0", m0_a_ready, 1);
        checkEq("t2_tie1_m1", m1_a_ready, 0);
        tick();
        m0_a_valid = 0;
        #1;
        checkEq("t2_grant0", grant, 0);
        checkEq("t2_sabits0", s_a_bits, bA0);
        s_a_ready = 1;
        tick();
        s_a_ready = 0;
        r0 = mkD(3'd0, 5'd1, 1'b0, 32'h0);
        s_d_valid = 1; s_d_bits = r0;
        #1;
        checkEq("t2_m0d", {m0_d_valid, m1_d_valid}, 2'b10);
        tick();
        s_d_valid = 0;
        #1;
        checkEq("t2_m1win", {m0_a_ready, m1_a_ready}, 2'b01);
        tick();
        m0_a_valid = 1;
        #1;
        checkEq("t2_grant1", grant, 1);
        checkEq("t2_sabits1", s_a_bits, bA1);
        s_a_ready = 1;
        tick();
        s_a_ready = 0;
        r1 = mkD(3'd1, 5'd2, 1'b0, 32'hCAFE_F00D);
        s_d_valid = 1; s_d_bits = r1;
        #1;
        checkEq("t2_m1d", {m0_d_valid, m1_d_valid}, 2'b01);
        checkEq("t2_m1dbits", m1_d_bits, r1);
        checkEq("t2_m0dbits", m0_d_bits, 0);
        checkEq("t2_noaccept_dw", {m0_a_ready, m1_a_ready}, 0);
        tick();
        s_d_valid = 0;
        #1;
        checkEq("t2_tie2", {m0_a_ready, m1_a_ready}, 2'b10);
        tick();
        m0_a_valid = 0; m1_a_valid = 0;
        #1;
        checkEq("t2_grant_alt", grant, 0);
        s_a_ready = 1;
        tick();
        s_a_ready = 0;
        s_d_valid = 1; s_d_bits = r0;
        tick();
        s_d_valid = 0;

        // Test 3: s_a_ready held low, A beat must stay stable; stale D absorbed
        bA3 = mkA(3'd1, 5'd7, 32'h8000_0300, 32'hA5A5_5A5A);
        m0_a_valid = 1; m0_a_bits = bA3;
        tick();
        m0_a_valid = 0; m0_a_bits = '1;
        m1_a_valid = 1;
        s_d_valid = 1; s_d_bits = mkD(3'd0, 5'd0, 1'b0, 32'h1111_1111);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkEq($sformatf("t3_hold%0d", i), {s_a_valid, s_a_bits}, {1'b1, bA3});
            checkEq($sformatf("t3_m1rdy%0d", i), m1_a_ready, 0);
            checkEq($sformatf("t3_stale%0d", i), {s_d_ready, m0_d_valid, m1_d_valid}, 3'b100);
            tick();
        end
        s_a_ready = 1;
        #1;
        checkEq("t3_hold5", {s_a_valid, s_a_bits}, {1'b1, bA3});
        tick();
        s_a_ready = 0; m1_a_valid = 0;
        r0 = mkD(3'd0, 5'd7, 1'b0, 32'h0);
        s_d_bits = r0;
        #1;
        checkEq("t3_resp", m0_d_bits, r0);
        tick();
        s_d_valid = 0;

        // Test 4: m1 Get never answered -> timeout after 8 D_WAIT cycles
        bA4 = mkA(3'd4, 5'd9, 32'h8000_0400, 32'h0);
        m1_a_valid = 1; m1_a_bits = bA4;
        #1;
        checkEq("t4_m1ready", m1_a_ready, 1);
        tick();
        m1_a_valid = 0;
        s_a_ready = 1;
        tick();
        s_a_ready = 0;
        for (int i = 1; i < 8; i++) begin
            #1;
            checkEq($sformatf("t4_wait%0d", i), {busy, timeout_pulse, m1_d_valid}, 3'b100);
            tick();
        end
        #1;
        checkEq("t4_pulse", timeout_pulse, 1);
        tick();
        #1;
        checkEq("t4_tresp_valid", {m0_d_valid, m1_d_valid}, 2'b01);
        checkEq("t4_tresp_bits", m1_d_bits, mkD(3'd1, 5'd9, 1'b1, 32'h0));
        checkEq("t4_tresp_sdready", s_d_ready, 0);
        checkEq("t4_pulse_off", timeout_pulse, 0);
        tick();
        #1;
        checkEq("t4_idle", busy, 0);

        // Test 5: m0 back-pressures D for 4 cycles
        m0_a_valid = 1; m0_a_bits = bA0;
        tick();
        m0_a_valid = 0;
        s_a_ready = 1;
        tick();
        s_a_ready = 0;
        r5 = mkD(3'd0, 5'd1, 1'b0, 32'h0BAD_F00D);
        s_d_valid = 1; s_d_bits = r5; m0_d_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkEq($sformatf("t5_bp%0d", i), {s_d_ready, m0_d_valid, busy}, 3'b011);
            tick();
        end
        m0_d_ready = 1;
        #1;
        checkEq("t5_deliver", {s_d_ready, m0_d_valid}, 2'b11);
        checkEq("t5_bits", m0_d_bits, r5);
        tick();
        s_d_valid = 0;
        #1;
        checkEq("t5_idle", {busy, m0_d_valid}, 2'b00);

        // Test 6: reset mid-D_WAIT, late response is swallowed
        m0_a_valid = 1; m0_a_bits = bA0;
        tick();
        m0_a_valid = 0;
        s_a_ready = 1;
        tick();
        s_a_ready = 0;
        #1;
        checkEq("t6_dwait", busy, 1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        checkEq("t6_rst_busy", busy, 0);
        s_d_valid = 1; s_d_bits = r5;
        #1;
        checkEq("t6_late", {s_d_ready, m0_d_valid, m1_d_valid}, 3'b100);
        tick();
        s_d_valid = 0;
        #1;
        checkEq("t6_still_idle", {busy, s_a_valid}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
